// File: rtl/wb_ctrl_if.sv
// Writeback sequencer bus: execute-stage issue handshake, data-memory
// read-valid and register-file write port.
interface wb_ctrl_if #(
    parameter int RW = 3
);
    logic                 issue_valid;
    logic [1:0]           issue_src;
    logic [RW-1:0]        issue_rd;
    logic                 issue_ready;
    logic                 dm_rdy;
    logic [1:0]           WBCR;
    logic                 rf_we;
    logic [RW-1:0]        rf_wa;
    logic [(1<<RW)-1:0]   pend_mask;
    logic                 dm_err;
    logic                 dm_spur;
    logic                 empty;

    modport master (
        output issue_valid, issue_src, issue_rd, dm_rdy,
        input  issue_ready, WBCR, rf_we, rf_wa,
        input  pend_mask, dm_err, dm_spur, empty
    );

    modport slave (
        input  issue_valid, issue_src, issue_rd, dm_rdy,
        output issue_ready, WBCR, rf_we, rf_wa,
        output pend_mask, dm_err, dm_spur, empty
    );
endinterface

// File: rtl/wb_ctrl.sv
// In-order writeback queue: one register-file write per cycle, loads wait
// for data-memory read-valid with a bounded timeout.
module wb_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15,
    parameter int RW      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_ctrl_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        WAIT_DM
    } state_t;

    logic [1:0]    src_q [DEPTH];
    logic [RW-1:0] rd_q  [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;
    logic [7:0]    wait_cnt;

    state_t        st;
    logic          push;
    logic          pop;
    logic          ready;
    logic [1:0]    head_src;
    logic [RW-1:0] head_rd;

    assign head_src = src_q[rptr];
    assign head_rd  = rd_q[rptr];
    assign ready    = (cnt != (AW+1)'(DEPTH));
    assign push     = bus.issue_valid && ready;

    assign bus.issue_ready = ready;
    assign bus.empty       = (cnt == '0);

    always_comb begin
        st = IDLE;
        if (cnt != '0)
            st = (head_src == 2'd1) ? WAIT_DM : COMMIT;
    end

    always_comb begin
        bus.rf_we  = 1'b0;
        bus.WBCR   = 2'd0;
        bus.rf_wa  = '0;
        bus.dm_err = 1'b0;
        pop        = 1'b0;
        unique case (st)
            COMMIT: begin
                bus.rf_we = 1'b1;
                bus.WBCR  = head_src;
                bus.rf_wa = head_rd;
                pop       = 1'b1;
            end
            WAIT_DM: begin
                // Read-valid beats the timeout when both land together
                if (bus.dm_rdy) begin
                    bus.rf_we = 1'b1;
                    bus.WBCR  = 2'd1;
                    bus.rf_wa = head_rd;
                    pop       = 1'b1;
                end else if (wait_cnt == 8'(TIMEOUT)) begin
                    bus.dm_err = 1'b1;
                    pop        = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Gated by reset so a stray read-valid during reset is not reported
    assign bus.dm_spur = rst_n && bus.dm_rdy && (st != WAIT_DM);

    always_comb begin
        bus.pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(cnt))
                bus.pend_mask[rd_q[rptr + AW'(i)]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            src_q[wptr] <= bus.issue_src;
            rd_q[wptr]  <= bus.issue_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            wait_cnt <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
            if (pop)
                wait_cnt <= '0;
            else if (st == WAIT_DM)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_wb_ctrl.sv
// Bench for wb_ctrl: queue-level reference model feeds an event scoreboard
// drained by an independent monitor.
module tb_wb_ctrl;
    localparam int DEPTH = 4;
    localparam int TMO   = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wb_ctrl_if #(.RW(3)) bus ();

    wb_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TMO), .RW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         cyc;
        bit         we;
        logic [1:0] src;
        logic [2:0] rd;
        bit         err;
        bit         spur;
    } ev_t;

    typedef struct {
        logic [1:0] src;
        logic [2:0] rd;
    } ent_t;

    ev_t  exp_q[$];
    ent_t mq[$];
    int   age = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, exp);
        end
    endtask

    // Monitor: compares every DUT event against the scoreboard
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_event cyc=%0d actual=none required=cyc%0d we%0d rd%0d err%0d",
                         cyc, exp_q[0].cyc, exp_q[0].we, exp_q[0].rd, exp_q[0].err);
                void'(exp_q.pop_front());
            end
            if (bus.rf_we || bus.dm_err || bus.dm_spur) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d actual=we%0d src%0d rd%0d err%0d spur%0d required=none",
                             cyc, bus.rf_we, bus.WBCR, bus.rf_wa, bus.dm_err, bus.dm_spur);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.we != bus.rf_we || e.src != bus.WBCR ||
                        e.rd != bus.rf_wa || e.err != bus.dm_err || e.spur != bus.dm_spur) begin
                        errors++;
                        $display("FAIL event cyc=%0d actual=we%0d src%0d rd%0d err%0d spur%0d required=cyc%0d we%0d src%0d rd%0d err%0d spur%0d",
                                 cyc, bus.rf_we, bus.WBCR, bus.rf_wa, bus.dm_err, bus.dm_spur,
                                 e.cyc, e.we, e.src, e.rd, e.err, e.spur);
                    end
                end
            end
        end
    end

    // One clock of stimulus; the model predicts events and level outputs
    task automatic cycle(input bit iv, input logic [1:0] s,
                         input logic [2:0] r, input bit dr);
        ev_t  e;
        bit   rdy;
        bit   pop;
        bit   ld;
        logic [7:0] pm;
        @(negedge clk);
        bus.issue_valid = iv;
        bus.issue_src   = s;
        bus.issue_rd    = r;
        bus.dm_rdy      = dr;
        rdy = (mq.size() != DEPTH);
        pm  = '0;
        foreach (mq[i]) pm[mq[i].rd] = 1'b1;
        e   = '{cyc: cyc, we: 0, src: 0, rd: 0, err: 0, spur: 0};
        pop = 0;
        ld  = (mq.size() != 0) && (mq[0].src == 2'd1);
        if (mq.size() != 0) begin
            if (!ld || dr) begin
                e.we  = 1;
                e.src = mq[0].src;
                e.rd  = mq[0].rd;
                pop   = 1;
            end else if (age == TMO) begin
                e.err = 1;
                pop   = 1;
            end else begin
                age++;
            end
        end
        e.spur = dr && !ld;
        if (e.we || e.err || e.spur)
            exp_q.push_back(e);
        #2;
        chk("issue_ready", int'(bus.issue_ready), int'(rdy));
        chk("empty", int'(bus.empty), int'(mq.size() == 0));
        chk("pend_mask", int'(bus.pend_mask), int'(pm));
        if (!e.we)
            chk("idle_mux", int'({bus.WBCR, bus.rf_wa}), 0);
        if (pop) begin
            void'(mq.pop_front());
            age = 0;
        end
        if (iv && rdy)
            mq.push_back('{src: s, rd: r});
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.issue_valid = 1'($urandom);
            bus.issue_src   = 2'($urandom);
            bus.issue_rd    = 3'($urandom);
            bus.dm_rdy      = 1'($urandom);
            exp_q.delete();
            mq.delete();
            age = 0;
            #1 rst_n = 1'b0;
            #1;
            chk("rst_rf_we", int'(bus.rf_we), 0);
            chk("rst_wbcr", int'(bus.WBCR), 0);
            chk("rst_rf_wa", int'(bus.rf_wa), 0);
            chk("rst_pend", int'(bus.pend_mask), 0);
            chk("rst_err", int'(bus.dm_err), 0);
            chk("rst_spur", int'(bus.dm_spur), 0);
            chk("rst_empty", int'(bus.empty), 1);
            chk("rst_ready", int'(bus.issue_ready), 1);
        end
        @(negedge clk);
        bus.issue_valid = 1'b0;
        bus.dm_rdy      = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 2'd0, 3'd0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.issue_valid = 1'b0;
        bus.issue_src   = 2'd0;
        bus.issue_rd    = 3'd0;
        bus.dm_rdy      = 1'b0;
        do_reset(4);

        // Single ALU write
        cycle(1, 2'd0, 3'd3, 0);
        idle(3);

        // Ordering behind a load, read-valid 4 cycles after it heads
        cycle(1, 2'd1, 3'd5, 0);
        cycle(1, 2'd2, 3'd2, 0);
        cycle(1, 2'd3, 3'd1, 0);
        idle(2);
        cycle(0, 2'd0, 3'd0, 1);
        idle(4);

        // Full queue holds a fifth request until the load commits
        cycle(1, 2'd1, 3'd4, 0);
        cycle(1, 2'd0, 3'd1, 0);
        cycle(1, 2'd2, 3'd2, 0);
        cycle(1, 2'd3, 3'd3, 0);
        cycle(1, 2'd0, 3'd7, 0);
        cycle(1, 2'd0, 3'd7, 1);
        cycle(1, 2'd0, 3'd7, 0);
        idle(5);

        // Timeout drop then following ALU commit
        cycle(1, 2'd1, 3'd6, 0);
        cycle(1, 2'd0, 3'd0, 0);
        idle(20);

        // Reset in the middle of a load wait with three queued
        cycle(1, 2'd1, 3'd2, 0);
        cycle(1, 2'd0, 3'd3, 0);
        cycle(1, 2'd2, 3'd4, 0);
        idle(3);
        do_reset(2);
        cycle(0, 2'd0, 3'd0, 1);
        idle(2);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 499) == 0)
                do_reset(1);
            cycle(1'($urandom_range(0, 2) != 0), 2'($urandom),
                  3'($urandom), $urandom_range(0, 7) == 0);
        end
        idle(40);
        @(negedge clk);
        #3;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_ctrl.md
# wb_ctrl

Writeback sequencer for the 8-bit RISC pipeline. It accepts in-order writeback requests from the execute stage and queues them. It drives the writeback mux select `WBCR` together with the register-file write strobe and address, so exactly one result is written per cycle in program order. Loads stall the queue head until data memory signals read-data valid, with a timeout. A pending-destination mask is exported to decode for hazard detection.

## Interface
- `DEPTH`, 4, request queue entries (power of two, ≥2)
- `TIMEOUT`, 15, max extra cycles a load head waits for `dm_rdy` (1..255)
- `RW`, 3, register address width (8 registers)

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `issue_valid`  in  1  execute stage presents a writeback request
- `issue_src`  in  2  result source: 0 ALU (`IALUD`), 1 data memory (`IDM`), 2 MOV (`IMOV`), 3 effective address (`Iea2`)
- `issue_rd`  in  RW  destination register
- `issue_ready`  out  1  queue can accept a request this cycle
- `dm_rdy`  in  1  data-memory read data valid on `IDM` this cycle
- `WBCR`  out  2  writeback mux select (same encoding as `issue_src`)
- `rf_we`  out  1  register-file write enable
- `rf_wa`  out  RW  register-file write address
- `pend_mask`  out  2^RW  bit r set while any queued entry targets register r
- `dm_err`  out  1  one-cycle pulse: load dropped on timeout
- `dm_spur`  out  1  one-cycle pulse: `dm_rdy` with no load at head
- `empty`  out  1  queue empty

## Operation
- The queue is a circular FIFO of {src, rd} with registered read and write pointers and a count.
- Enqueue happens on a rising edge when `issue_valid && issue_ready`.
- `issue_ready = (count != DEPTH)`. A pop in the same cycle does not raise ready; full means stall even if the head commits.
- The head state machine is derived from the registered queue state:
  - IDLE: count = 0. `rf_we` = 0.
  - COMMIT: head src ≠ 1. `rf_we` = 1, `WBCR` = head src, `rf_wa` = head rd. Pop at end of cycle.
  - WAIT_DM: head src = 1.
    - If `dm_rdy` = 1: commit as above with `WBCR` = 1 and pop.
    - Else if `wait_cnt` == TIMEOUT: `dm_err` = 1, pop without write (`rf_we` = 0).
    - Else: `wait_cnt` increments.
- `wait_cnt` is 8 bits. It clears on every pop and on reset.
- If `dm_rdy` and the timeout coincide, `dm_rdy` wins: the commit happens and no error is flagged.
- `dm_spur` = `dm_rdy` when the state is not WAIT_DM. No write results from it.
- `WBCR`, `rf_wa` and `rf_we` are combinational from registered head state and `dm_rdy`. When idle or waiting, `WBCR` = 0 and `rf_wa` = 0.
- `pend_mask` = OR of decode(rd) over all valid entries, from registered state. A bit stays set until the last entry for that register pops.
- Simultaneous enqueue and pop: both occur and the count is unchanged. Pointers wrap modulo DEPTH.
- Reset (async, any time, including mid-wait):
  - Pointers, count and `wait_cnt` clear.
  - Outputs: `rf_we` 0, `WBCR` 0, `rf_wa` 0, `pend_mask` 0, `dm_err` 0, `dm_spur` 0, `empty` 1, `issue_ready` 1.
  - Queued requests are lost.

## Timing
- Minimum latency: a request accepted at edge k is written in the cycle following edge k (commit cycle k+1), with no bypass.
- Throughput: one commit per cycle for non-load sources.
- A load head that becomes head in cycle j commits in the first cycle t ≥ j with `dm_rdy` = 1, provided t ≤ j+TIMEOUT.
- With no `dm_rdy`, the load is dropped in cycle j+TIMEOUT, where `dm_err` pulses.
- The entry behind the head commits in the cycle after the head pops at the earliest.
- `pend_mask` bit for a request is set from the cycle after acceptance and cleared in the cycle after its commit or drop.
- The `IDM` data must be valid in the same cycle as `dm_rdy`. The mux path is combinational.

## Test plan
- Reset: hold `rst_n` = 0 with random inputs → `rf_we` 0, `WBCR` 0, `pend_mask` 0, `empty` 1, `issue_ready` 1.
- Single ALU: issue src 0, rd 3 at edge k → cycle k+1 has `rf_we` 1, `WBCR` 0, `rf_wa` 3, `pend_mask` 0x08; the cycle after, `pend_mask` 0x00 and `empty` 1.
- Ordering: issue load→r5, MOV→r2, EA→r1 back-to-back, with `dm_rdy` 4 cycles after the load becomes head → writes r5 (`WBCR` 1), r2 (2), r1 (3) on consecutive cycles, none before the load.
- Full: load at head with 3 further issues queued (4 total) → `issue_ready` 0 and a 5th request is held. A `dm_rdy` pulse commits the load; `issue_ready` is 1 the next cycle and the held request is accepted.
- Timeout: load→r6 then ALU→r0 with no `dm_rdy` → `dm_err` pulses exactly 15 cycles after the load became head with `rf_we` 0. r0 commits the next cycle; bit 6 of `pend_mask` clears.
- Reset mid-wait: assert `rst_n` = 0 during WAIT_DM with 3 entries queued → all state clears immediately. After release, a `dm_rdy` pulse gives `dm_spur` 1 and `rf_we` 0.
